multi_channel_controller: RTL and testbench

- Parametrised successor to the single-channel filter controller.
- Sequences a filter engine over BLOCK_LEN samples per enabled channel, for up to N_CH channels.
- Per sample: issues a memory read, runs the filter with an enable/done handshake, then writes the filter result back to a separate output region.
- Sits between the top-level start logic, the filter datapath and the shared sample memory.

---
 rtl/ctrl_pkg.sv | 24 ++
 rtl/ctrl_chan_sel.sv | 32 +++
 rtl/multi_channel_controller.sv | 212 +++++++++++++++++++++
 tb/tb_multi_channel_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-channel filter controller.
//   - ctrl_state_e : FSM state encoding
//   - MEM_*        : Ctrl_MEMRW command codes
//   - ch_width()   : width of a channel index for a given channel count (minimum 1)
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StRd,
        StFilt,
        StWr,
        StDone
    } ctrl_state_e;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_chan_sel.sv
// ctrl_chan_sel: combinational finder for the lowest enabled channel at or above ch_i.
// Ports:
//   mask_i    - latched channel enable mask
//   ch_i      - current channel index; one bit wider than a channel number so that
//               it can point past the last channel
//   found_o   - an enabled channel >= ch_i exists
//   next_ch_o - that channel (0 when none found)
module ctrl_chan_sel
    import ctrl_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] mask_i,
    input  logic [CH_W:0]   ch_i,
    output logic            found_o,
    output logic [CH_W-1:0] next_ch_o
);

    always_comb begin
        found_o   = 1'b0;
        next_ch_o = '0;
        // Scan downwards so the lowest qualifying channel is the last one assigned.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(ch_i))) begin
                found_o   = 1'b1;
                next_ch_o = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/multi_channel_controller.sv
// multi_channel_controller: sequences a filter engine over BLOCK_LEN samples for each
// enabled channel. Per sample: memory read, filter enable/done handshake, write-back
// of the filter result to the output region.
// Ports:
//   Ctrl_CLK, Ctrl_RST          - clock, synchronous active-high reset
//   Ctrl_STRT, Ctrl_CHMASK      - start request and channel mask (latched on start)
//   Ctrl_BUSY, Ctrl_DNE         - run in progress, one-cycle completion pulse
//   Ctrl_FEN, Ctrl_FCH          - filter enable and channel being filtered
//   Ctrl_FDNE, Ctrl_FDATA       - filter done and result
//   Ctrl_MEMRW, Ctrl_MEMADDR,
//   Ctrl_MEMWDATA               - memory command (00 idle, 01 read, 10 write), address, data
//   Ctrl_ERR                    - sticky filter timeout error
// Build option: define CTRL_TIMEOUT_EN to abort a run when the filter does not answer
// within TIMEOUT_CYC cycles; otherwise FILT waits forever and Ctrl_ERR is 0.
// All outputs are registered from the next-state values.
module multi_channel_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 24,
    parameter int unsigned          BUS_WIDTH   = 32,
    parameter int unsigned          N_CH        = 4,
    parameter int unsigned          BLOCK_LEN   = 256,
    parameter logic [BUS_WIDTH-1:0] IN_BASE     = '0,
    parameter logic [BUS_WIDTH-1:0] OUT_BASE    = BUS_WIDTH'(32'h0001_0000),
    parameter int unsigned          TIMEOUT_CYC = 1024
) (
    input  logic                         Ctrl_CLK,
    input  logic                         Ctrl_RST,
    input  logic                         Ctrl_STRT,
    input  logic [N_CH-1:0]              Ctrl_CHMASK,
    output logic                         Ctrl_BUSY,
    output logic                         Ctrl_FEN,
    output logic [ch_width(N_CH)-1:0]    Ctrl_FCH,
    input  logic                         Ctrl_FDNE,
    input  logic [DATA_WIDTH-1:0]        Ctrl_FDATA,
    output logic [1:0]                   Ctrl_MEMRW,
    output logic [BUS_WIDTH-1:0]         Ctrl_MEMADDR,
    output logic [DATA_WIDTH-1:0]        Ctrl_MEMWDATA,
    output logic                         Ctrl_DNE,
    output logic                         Ctrl_ERR
);

    localparam int unsigned ChW  = ch_width(N_CH);
    localparam int unsigned IdxW = $clog2(BLOCK_LEN);

    ctrl_state_e           state_q, state_d;
    logic [N_CH-1:0]       mask_q, mask_d;
    logic [ChW:0]          ch_q, ch_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

    logic                  busy_q, fen_q, dne_q;
    logic [ChW-1:0]        fch_q;
    logic [1:0]            memrw_q, memrw_d;
    logic [BUS_WIDTH-1:0]  memaddr_q, memaddr_d, off_d;
    logic [DATA_WIDTH-1:0] memwdata_q, memwdata_d;

    logic                  sel_found;
    logic [ChW-1:0]        sel_ch;
    logic                  timeout;
    logic                  start_acc;

    assign start_acc = (state_q == StIdle) && Ctrl_STRT;

    ctrl_chan_sel #(
        .N_CH (N_CH),
        .CH_W (ChW)
    ) u_chan_sel (
        .mask_i    (mask_q),
        .ch_i      (ch_q),
        .found_o   (sel_found),
        .next_ch_o (sel_ch)
    );

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            err_q, err_d;

    // A done arriving in the expiry cycle wins, so expiry is gated by Ctrl_FDNE.
    assign timeout = (state_q == StFilt) && !Ctrl_FDNE && (tmr_q == TmrW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmr_d = (state_q == StFilt) ? tmr_q + 1'b1 : '0;
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign Ctrl_ERR = err_q;
`else
    assign timeout  = 1'b0;
    assign Ctrl_ERR = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        fdata_d = fdata_q;
        unique case (state_q)
            StIdle: begin
                if (Ctrl_STRT) begin
                    mask_d  = Ctrl_CHMASK;
                    ch_d    = '0;
                    state_d = StSel;
                end
            end
            StSel: begin
                if (sel_found) begin
                    ch_d    = {1'b0, sel_ch};
                    idx_d   = '0;
                    state_d = StRd;
                end else begin
                    state_d = StDone;
                end
            end
            StRd: state_d = StFilt;
            StFilt: begin
                if (Ctrl_FDNE) begin
                    fdata_d = Ctrl_FDATA;
                    state_d = StWr;
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                if (idx_q == '1) begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StSel;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the upcoming state so every output is a plain register.
    // BLOCK_LEN is a power of two, so ch*BLOCK_LEN + idx is a concatenation.
    always_comb begin
        off_d      = BUS_WIDTH'({ch_d[ChW-1:0], idx_d});
        memrw_d    = MEM_IDLE;
        memaddr_d  = '0;
        memwdata_d = '0;
        if (state_d == StRd) begin
            memrw_d   = MEM_RD;
            memaddr_d = IN_BASE + off_d;
        end else if (state_d == StWr) begin
            memrw_d    = MEM_WR;
            memaddr_d  = OUT_BASE + off_d;
            memwdata_d = fdata_d;
        end
    end

    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            fdata_q    <= '0;
            busy_q     <= 1'b0;
            fen_q      <= 1'b0;
            fch_q      <= '0;
            dne_q      <= 1'b0;
            memrw_q    <= MEM_IDLE;
            memaddr_q  <= '0;
            memwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            idx_q      <= idx_d;
            fdata_q    <= fdata_d;
            busy_q     <= (state_d != StIdle);
            fen_q      <= (state_d == StFilt);
            fch_q      <= (state_d == StFilt) ? ch_d[ChW-1:0] : fch_q;
            dne_q      <= (state_d == StDone);
            memrw_q    <= memrw_d;
            memaddr_q  <= memaddr_d;
            memwdata_q <= memwdata_d;
        end
    end

    assign Ctrl_BUSY     = busy_q;
    assign Ctrl_FEN      = fen_q;
    assign Ctrl_FCH      = fch_q;
    assign Ctrl_DNE      = dne_q;
    assign Ctrl_MEMRW    = memrw_q;
    assign Ctrl_MEMADDR  = memaddr_q;
    assign Ctrl_MEMWDATA = memwdata_q;

endmodule

// File: tb/tb_multi_channel_controller.sv
// Testbench for multi_channel_controller with N_CH=2, BLOCK_LEN=4, IN_BASE=0x1000,
// OUT_BASE=0x2000. The filter model raises FDNE two cycles after FEN rises (3 FILT cycles).
// The timeout sequence runs only when CTRL_TIMEOUT_EN is defined (TIMEOUT_CYC=8).
module tb_multi_channel_controller;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt;
    logic [1:0]  chmask;
    logic        busy, fen, fch, fdne, dne, err;
    logic [23:0] fdata, memwdata;
    logic [1:0]  memrw;
    logic [31:0] memaddr;

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [23:0] data;
    } acc_t;

    typedef struct {
        logic [1:0] mask;
        int         n_acc;
        int         dne_lat;
        int         fen_cyc;
    } vec_t;

    acc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   fen_cnt = 0;
    int   dne_cnt = 0;
    int   ops = 0;
    int   fen_run = 0;
    bit   hold_fdne = 1'b0;
    logic last_rd_ch = 1'b0;

    always #5 clk = ~clk;

    multi_channel_controller #(
        .DATA_WIDTH  (24),
        .BUS_WIDTH   (32),
        .N_CH        (2),
        .BLOCK_LEN   (4),
        .IN_BASE     (32'h0000_1000),
        .OUT_BASE    (32'h0000_2000),
        .TIMEOUT_CYC (8)
    ) dut (
        .Ctrl_CLK      (clk),
        .Ctrl_RST      (rst),
        .Ctrl_STRT     (strt),
        .Ctrl_CHMASK   (chmask),
        .Ctrl_BUSY     (busy),
        .Ctrl_FEN      (fen),
        .Ctrl_FCH      (fch),
        .Ctrl_FDNE     (fdne),
        .Ctrl_FDATA    (fdata),
        .Ctrl_MEMRW    (memrw),
        .Ctrl_MEMADDR  (memaddr),
        .Ctrl_MEMWDATA (memwdata),
        .Ctrl_DNE      (dne),
        .Ctrl_ERR      (err)
    );

    function automatic logic [23:0] data_of(input int k);
        return 24'h5A0000 ^ 24'(k * 32'h010203);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Filter model: result k of a run is data_of(k); ops advances once FDNE was taken.
    initial begin
        fdne  = 1'b0;
        fdata = 24'hDEAD00;
        forever begin
            @(posedge clk);
            #1;
            if (fdne) ops++;
            if (fen && !hold_fdne) fen_run++;
            else fen_run = 0;
            fdne  = (fen_run >= 3);
            fdata = fdne ? data_of(ops) : 24'hDEAD00;
        end
    end

    // Scoreboard: every memory access pops the next expected access.
    initial begin
        acc_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dne) dne_cnt++;
            if (fen) begin
                fen_cnt++;
                check("fch_matches_read_ch", 32'(fch), 32'(last_rd_ch));
            end
            if (memrw != MEM_IDLE) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got rw=%b addr=0x%0h, required none",
                             memrw, memaddr);
                end else begin
                    e = exp_q.pop_front();
                    check("memrw", 32'(memrw), 32'(e.rw));
                    check("memaddr", memaddr, e.addr);
                    if (e.rw == MEM_WR) check("memwdata", 32'(memwdata), 32'(e.data));
                end
                if (memrw == MEM_RD) last_rd_ch = memaddr[2];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    task automatic push_run(input logic [1:0] m);
        int k = 0;
        for (int c = 0; c < 2; c++) begin
            if (m[c]) begin
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back('{MEM_RD, 32'h1000 + 32'(c * 4 + i), 24'h0});
                    exp_q.push_back('{MEM_WR, 32'h2000 + 32'(c * 4 + i), data_of(k)});
                    k++;
                end
            end
        end
    endtask

    task automatic start(input logic [1:0] m);
        acc_cnt = 0;
        fen_cnt = 0;
        dne_cnt = 0;
        ops     = 0;
        chmask  = m;
        strt    = 1'b1;
        @(posedge clk);
        #1;
        strt = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // lat counts edges from the start edge (edge 1) to the edge that shows DNE.
    task automatic wait_dne(input int base, output int lat);
        bit got = 1'b0;
        lat = base;
        for (int n = 0; n < 300 && !got; n++) begin
            if (dne) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL dne_timeout: got no DNE in 300 cycles, required a pulse");
        end
    endtask

    task automatic check_zero();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fen", 32'(fen), 32'd0);
        check("rst_fch", 32'(fch), 32'd0);
        check("rst_memrw", 32'(memrw), 32'd0);
        check("rst_memaddr", memaddr, 32'd0);
        check("rst_memwdata", 32'(memwdata), 32'd0);
        check("rst_dne", 32'(dne), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        push_run(v.mask);
        start(v.mask);
        wait_dne(1, lat);
        check("dne_latency", lat, v.dne_lat);
        repeat (3) @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("dne_pulses", dne_cnt, 1);
        check("access_count", acc_cnt, v.n_acc);
        check("fen_cycles", fen_cnt, v.fen_cyc);
        check("queue_drained", exp_q.size(), 0);
        check("err_clear", 32'(err), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   lat;
        bit   hit;

        vecs[0] = '{2'b11, 16, 44, 24};
        vecs[1] = '{2'b10,  8, 23, 12};
        vecs[2] = '{2'b00,  0,  2,  0};
        vecs[3] = '{2'b01,  8, 23, 12};

        rst    = 1'b1;
        strt   = 1'b0;
        chmask = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_zero();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero();

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Reset during FILT of ch0 idx2: 5 accesses done, 11 still expected.
        push_run(2'b11);
        start(2'b11);
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            if (fen && exp_q.size() == 11) begin
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("reached_filt_ch0_idx2", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero();
        check("pending_after_reset", exp_q.size(), 11);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 32'd0);
        run_vec(vecs[0]);

        // STRT mid-run and in the DONE cycle are ignored.
        push_run(2'b11);
        start(2'b11);
        repeat (10) @(posedge clk);
        #1;
        chmask = 2'b01;
        strt   = 1'b1;
        @(posedge clk);
        #1;
        strt = 1'b0;
        wait_dne(12, lat);
        check("midrun_latency", lat, 44);
        strt = 1'b1;
        @(posedge clk);
        #1;
        strt = 1'b0;
        check("busy_after_done_strt", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("ignored_access_count", acc_cnt, 16);
        check("ignored_dne_pulses", dne_cnt, 1);
        check("ignored_queue", exp_q.size(), 0);
        check("ignored_busy", 32'(busy), 32'd0);

`ifdef CTRL_TIMEOUT_EN
        // Filter never answers: 8 FEN cycles, then ERR and DNE with no write.
        hold_fdne = 1'b1;
        exp_q.push_back('{MEM_RD, 32'h1000, 24'h0});
        start(2'b01);
        wait_dne(1, lat);
        check("timeout_latency", lat, 11);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_fen_cycles", fen_cnt, 8);
        check("timeout_accesses", acc_cnt, 1);
        hold_fdne = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        start(2'b00);
        check("err_cleared_by_start", 32'(err), 32'd0);
        wait_dne(1, lat);
        check("post_timeout_latency", lat, 2);
        repeat (2) @(posedge clk);
        #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
